// File: rtl/pmc_code_mem.sv
// rtl/pmc_code_mem.sv - coprocessor instruction store with fetch port and bus access (optional PMC_CODE_PARITY_EN)
module pmc_code_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_if,
    output logic [31:0]   instr,
    input  logic          pmcc_running,
    input  logic          bus_req,
    input  logic          bus_we,
    input  logic [AW-1:0] bus_addr,
    input  logic [31:0]   bus_wdata,
    input  logic [3:0]    bus_be,
    output logic          bus_gnt,
    output logic          bus_rvalid,
    output logic [31:0]   bus_rdata,
    output logic          wr_err,
    input  logic          err_clr,
    output logic          par_err
);

    typedef enum logic {
        IDLE_BUS = 1'b0,
        FETCH    = 1'b1
    } port_state_e;

    logic [31:0] mem [DEPTH];

    port_state_e port_state;
    logic        rd_gnt;
    logic        wr_gnt;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] old_word;

    logic [31:0] instr_q,      instr_d;
    logic        bus_rvalid_q, bus_rvalid_d;
    logic [31:0] bus_rdata_q,  bus_rdata_d;
    logic        wr_err_q,     wr_err_d;

`ifdef PMC_CODE_PARITY_EN
    logic        par_mem [DEPTH];
    logic        par_err_q, par_err_d;
    logic        rmw_q,     rmw_d;
    logic        partial_wr;
`endif

    // Port ownership, grants, byte merge and next-state of all registers
    always_comb begin
        port_state = pmcc_running ? FETCH : IDLE_BUS;
        old_word   = mem[bus_addr];
        for (int b = 0; b < 4; b++) begin
            mem_wdata[8*b +: 8] = bus_be[b] ? bus_wdata[8*b +: 8] : old_word[8*b +: 8];
        end

        rd_gnt = !rst && (port_state == IDLE_BUS) && bus_req && !bus_we;
`ifdef PMC_CODE_PARITY_EN
        // Partial writes spend one stall cycle reading the old word before the merged write
        partial_wr = (port_state == IDLE_BUS) && bus_req && bus_we && (bus_be != 4'hF);
        rmw_d      = !rst && partial_wr && !rmw_q;
        wr_gnt     = !rst && bus_req && bus_we &&
                     ((port_state == FETCH) || (bus_be == 4'hF) || rmw_q);
`else
        // Writes during FETCH are still granted so the bus never hangs
        wr_gnt     = !rst && bus_req && bus_we;
`endif
        mem_we  = wr_gnt && (port_state == IDLE_BUS);
        bus_gnt = rd_gnt || wr_gnt;

        instr_d      = (port_state == FETCH) ? mem[pc_if] : instr_q;
        bus_rvalid_d = rd_gnt;
        bus_rdata_d  = rd_gnt ? old_word : bus_rdata_q;

        // Set has priority over clear
        wr_err_d = wr_err_q;
        if (err_clr) begin
            wr_err_d = 1'b0;
        end
        if (wr_gnt && (port_state == FETCH)) begin
            wr_err_d = 1'b1;
        end

`ifdef PMC_CODE_PARITY_EN
        par_err_d = par_err_q;
        if (err_clr) begin
            par_err_d = 1'b0;
        end
        if ((port_state == FETCH) && ((^mem[pc_if]) != par_mem[pc_if])) begin
            par_err_d = 1'b1;
        end
`endif
    end

    // Output and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q      <= 32'h0;
            bus_rvalid_q <= 1'b0;
            bus_rdata_q  <= 32'h0;
            wr_err_q     <= 1'b0;
`ifdef PMC_CODE_PARITY_EN
            par_err_q    <= 1'b0;
            rmw_q        <= 1'b0;
`endif
        end else begin
            instr_q      <= instr_d;
            bus_rvalid_q <= bus_rvalid_d;
            bus_rdata_q  <= bus_rdata_d;
            wr_err_q     <= wr_err_d;
`ifdef PMC_CODE_PARITY_EN
            par_err_q    <= par_err_d;
            rmw_q        <= rmw_d;
`endif
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[bus_addr] <= mem_wdata;
`ifdef PMC_CODE_PARITY_EN
            par_mem[bus_addr] <= ^mem_wdata;
`endif
        end
    end

    assign instr      = instr_q;
    assign bus_rvalid = bus_rvalid_q;
    assign bus_rdata  = bus_rdata_q;
    assign wr_err     = wr_err_q;
`ifdef PMC_CODE_PARITY_EN
    assign par_err    = par_err_q;
`else
    assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pmc_code_mem.sv
// tb/tb_pmc_code_mem.sv - scoreboard bench for pmc_code_mem
module tb_pmc_code_mem;

    localparam int AW = 10;
`ifdef PMC_CODE_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_if;
    logic [31:0]   instr;
    logic          pmcc_running;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata;
    logic [3:0]    bus_be;
    logic          bus_gnt;
    logic          bus_rvalid;
    logic [31:0]   bus_rdata;
    logic          wr_err;
    logic          err_clr;
    logic          par_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [1024];
    logic [31:0] rd_q [$];
    logic [31:0] instr_q [$];

    pmc_code_mem #(.DEPTH(1024), .AW(AW)) dut (
        .clk(clk), .rst(rst), .pc_if(pc_if), .instr(instr),
        .pmcc_running(pmcc_running), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .wr_err(wr_err), .err_clr(err_clr), .par_err(par_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Read-data scoreboard: every bus_rvalid pops one expected word
    always @(negedge clk) begin
        if (!rst && bus_rvalid) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected rdata=%h", bus_rdata);
            end else begin
                logic [31:0] exp_rd;
                exp_rd = rd_q.pop_front();
                if (bus_rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL rdata got=%h exp=%h", bus_rdata, exp_rd);
                end
            end
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? d[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    task automatic bus_op(input logic we, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        int waited;
        int exp_wait;
        waited = 0;
        exp_wait = (PAR && we && be != 4'hF && !pmcc_running) ? 1 : 0;
        @(negedge clk);
        bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d; bus_be = be;
        #1;
        while (!bus_gnt && waited < 8) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checks++;
        if (!bus_gnt) begin
            errors++;
            $display("FAIL gnt_timeout addr=%h we=%0d waited=%0d", a, we, waited);
        end else begin
            if (waited != exp_wait) begin
                errors++;
                $display("FAIL gnt_latency addr=%h got=%0d exp=%0d", a, waited, exp_wait);
            end
            if (!we) rd_q.push_back(model[a]);
            else if (!pmcc_running) model[a] = merge(model[a], d, be);
        end
    endtask

    task automatic bus_idle();
        @(negedge clk);
        bus_req = 1'b0;
        bus_we  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pmcc_running = 1'b0; pc_if = '0; err_clr = 1'b0;
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 10'h001; bus_wdata = '0; bus_be = 4'hF;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus_gnt !== 1'b0) begin errors++; $display("FAIL gnt_in_reset got=%b exp=0", bus_gnt); end
        checks++;
        if ({instr, bus_rdata, bus_rvalid, wr_err, par_err} !== 67'h0) begin
            errors++;
            $display("FAIL reset_state instr=%h rdata=%h rvalid=%b wr_err=%b par_err=%b exp=all zero",
                     instr, bus_rdata, bus_rvalid, wr_err, par_err);
        end
        bus_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        bus_op(1'b1, 10'h005, 32'hA5A5_1234, 4'hF);
        bus_op(1'b0, 10'h005, 32'h0, 4'h0);
        bus_idle();
    endtask

    task automatic test_fetch();
        for (int i = 0; i < 4; i++) bus_op(1'b1, AW'(i), 32'h10 + 32'(i), 4'hF);
        bus_idle();
        pmcc_running = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc_if = AW'(i);
            instr_q.push_back(model[i]);
            @(negedge clk);
            begin
                logic [31:0] exp_i;
                exp_i = instr_q.pop_front();
                checks++;
                if (instr !== exp_i) begin
                    errors++;
                    $display("FAIL fetch pc=%0d got=%h exp=%h", i, instr, exp_i);
                end
            end
        end
        pmcc_running = 1'b0;
        @(negedge clk);
        checks++;
        if (instr !== 32'h13) begin errors++; $display("FAIL instr_hold got=%h exp=%h", instr, 32'h13); end
    endtask

    task automatic test_write_in_fetch();
        @(negedge clk);
        pmcc_running = 1'b1;
        bus_op(1'b1, 10'h002, 32'hFFFF_FFFF, 4'hF);
        bus_idle();
        checks++;
        if (wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_set got=%b exp=1", wr_err); end
        err_clr = 1'b1;
        bus_op(1'b1, 10'h002, 32'hFFFF_FFFF, 4'hF);
        bus_idle();
        checks++;
        if (wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_set_wins got=%b exp=1", wr_err); end
        @(negedge clk);
        checks++;
        if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_clear got=%b exp=0", wr_err); end
        err_clr = 1'b0;
        pmcc_running = 1'b0;
        bus_op(1'b0, 10'h002, 32'h0, 4'h0);
        bus_idle();
        @(negedge clk);
    endtask

    task automatic test_stall();
        @(negedge clk);
        pmcc_running = 1'b1;
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 10'h001;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus_gnt !== 1'b0) begin errors++; $display("FAIL stall_gnt cycle=%0d got=%b exp=0", i, bus_gnt); end
            @(negedge clk);
        end
        pmcc_running = 1'b0;
        #1;
        checks++;
        if (bus_gnt !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_gnt got=%b exp=1", bus_gnt);
        end else begin
            rd_q.push_back(model[1]);
        end
        bus_idle();
        @(negedge clk);
    endtask

    task automatic test_byte_write();
        bus_op(1'b1, 10'h000, 32'h00AB_0000, 4'b0100);
        bus_op(1'b0, 10'h000, 32'h0, 4'h0);
        bus_op(1'b1, 10'h001, 32'hDEAD_BEEF, 4'b0000);
        bus_op(1'b0, 10'h001, 32'h0, 4'h0);
        bus_idle();
        checks++;
        if (model[0] !== 32'h00AB_0010 || model[1] !== 32'h11) begin
            errors++;
            $display("FAIL model_byte_merge got=%h/%h exp=00ab0010/00000011", model[0], model[1]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            logic [31:0] w;
            w = $urandom;
            bus_op(1'b1, AW'(10'h100 + i), w, 4'hF);
            bus_op(1'b0, AW'(10'h100 + i), 32'h0, 4'h0);
            bus_op(1'b0, 10'h005, 32'h0, 4'h0);
        end
        bus_idle();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_parity();
        @(negedge clk);
`ifdef PMC_CODE_PARITY_EN
        dut.mem[3] = dut.mem[3] ^ 32'h0000_0100;
`endif
        pmcc_running = 1'b1;
        pc_if = 10'h003;
        @(negedge clk);
        checks++;
        if (par_err !== PAR) begin errors++; $display("FAIL par_err got=%b exp=%b", par_err, PAR); end
        pmcc_running = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (par_err !== 1'b0) begin errors++; $display("FAIL par_err_clear got=%b exp=0", par_err); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fetch();
        test_write_in_fetch();
        test_stall();
        test_byte_write();
        test_back_to_back();
        test_parity();
        repeat (3) @(negedge clk);
        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL rd_queue_drained got=%0d exp=0", rd_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
